// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the debug dump FSM states.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dump_state_t;
endpackage

// File: rtl/regfile_dump_if.sv
// Register-file read ports plus the (index, value) output stream of the dump engine.
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_idx;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output rd_addr_a, rd_addr_b, out_valid, out_idx, out_data, out_last,
    input  rd_data_a, rd_data_b, out_ready
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, out_valid, out_idx, out_data, out_last,
    output rd_data_a, rd_data_b, out_ready
  );
endinterface

// File: rtl/dump_out_buf.sv
// Two-entry holding buffer: presents the fetched pair one word at a time on valid/ready.
module dump_out_buf
  import cpu_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [ADDR_W-1:0] base_idx,
  input  logic [ADDR_W-1:0] end_idx,
  input  logic              pair,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              fin,
  output logic              fin_last
);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  logic              out_valid_r;
  logic [ADDR_W-1:0] out_idx_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_last_r;
  logic [DATA_W-1:0] buf1_r;
  logic              pair_r;
  logic              sel_r;
  logic              last1_r;
  logic              hs_s;

  assign hs_s      = out_valid_r & out_ready;
  assign fin       = hs_s & (sel_r | ~pair_r);
  assign fin_last  = out_last_r;
  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;

  // Flush beats a same-cycle handshake; word 1 follows word 0 with no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_idx_r   <= '0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      buf1_r      <= '0;
      pair_r      <= 1'b0;
      sel_r       <= 1'b0;
      last1_r     <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      sel_r       <= 1'b0;
    end else if (load) begin
      out_valid_r <= 1'b1;
      out_idx_r   <= base_idx;
      out_data_r  <= data_a;
      out_last_r  <= ~pair;
      buf1_r      <= data_b;
      pair_r      <= pair;
      sel_r       <= 1'b0;
      last1_r     <= ((base_idx + IDX_ONE) == end_idx);
    end else if (hs_s) begin
      if (!sel_r && pair_r) begin
        sel_r      <= 1'b1;
        out_idx_r  <= out_idx_r + IDX_ONE;
        out_data_r <= buf1_r;
        out_last_r <= last1_r;
      end else begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
        sel_r       <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks an inclusive register range two registers per fetch
// through the regfile read ports and streams (index, value) pairs.
module regfile_dump
  import cpu_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W-1:0] last,
  input  logic              abort,
  regfile_dump_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_TWO   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] IDX_THREE = ADDR_W'(3);

  dump_state_t       state_r;
  logic [ADDR_W-1:0] cur_r;
  logic [ADDR_W-1:0] end_r;
  logic [ADDR_W-1:0] rd_addr_a_r;
  logic [ADDR_W-1:0] rd_addr_b_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              load_s;
  logic              flush_s;
  logic              pair_s;
  logic              fin_s;
  logic              fin_last_s;

  assign load_s        = (state_r == FETCH) && !abort;
  assign flush_s       = abort && (state_r != IDLE);
  assign pair_s        = (cur_r != end_r);
  assign bus.rd_addr_a = rd_addr_a_r;
  assign bus.rd_addr_b = rd_addr_b_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

  dump_out_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .flush    (flush_s),
    .base_idx (cur_r),
    .end_idx  (end_r),
    .pair     (pair_s),
    .data_a   (bus.rd_data_a),
    .data_b   (bus.rd_data_b),
    .out_ready(bus.out_ready),
    .out_valid(bus.out_valid),
    .out_idx  (bus.out_idx),
    .out_data (bus.out_data),
    .out_last (bus.out_last),
    .fin      (fin_s),
    .fin_last (fin_last_s)
  );

  // Read addresses are registered so they are only non-zero for the FETCH cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cur_r       <= '0;
      end_r       <= '0;
      rd_addr_a_r <= '0;
      rd_addr_b_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      rd_addr_a_r <= '0;
      rd_addr_b_r <= '0;
      if (flush_s) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              if (first <= last) begin
                cur_r       <= first;
                end_r       <= last;
                rd_addr_a_r <= first;
                rd_addr_b_r <= first + IDX_ONE;
                busy_r      <= 1'b1;
                state_r     <= FETCH;
              end else begin
                err_r <= 1'b1;
              end
            end
          end
          FETCH: state_r <= DRAIN;
          DRAIN: begin
            if (fin_s) begin
              if (fin_last_s) begin
                done_r  <= 1'b1;
                state_r <= DONE;
              end else begin
                cur_r       <= cur_r + IDX_TWO;
                rd_addr_a_r <= cur_r + IDX_TWO;
                rd_addr_b_r <= cur_r + IDX_THREE;
                state_r     <= FETCH;
              end
            end
          end
          DONE: begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end
endmodule
